alu_flag_context_store: RTL and testbench
=========================================

Name: alu_flag_context_store

Overview:
- Saves and restores per-process ALU flag snapshots across context switches.
- Captures the ALU's exported {zero, sign, carry, overflow} flags into a slot indexed by process number.
- Drives the ALU's savedFlags / loadFlagsFromSavedState inputs to reinstate another slot's flags.
- Sits between the scheduler/context-switch controller and the ALU.

Parameters:
- slotBits, 3, log2 of the number of process slots (2**slotBits slots, each holding 4 flag bits plus 1 valid bit)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- switchRequest  input  1  start a context switch; sampled only in IDLE
- doSave  input  1  qualifies switchRequest: save current ALU flags to fromSlot
- doRestore  input  1  qualifies switchRequest: restore toSlot flags into ALU
- fromSlot  input  slotBits  slot written by the save phase
- toSlot  input  slotBits  slot read by the restore phase
- invalidate  input  1  clear valid bit of invalidateSlot; accepted only in IDLE
- invalidateSlot  input  slotBits  slot to invalidate
- aluFlags  input  4  ALU exported flags {Z,S,C,V}
- aluUpdateFlags  input  1  ALU updateFlags for the current cycle
- savedFlags  output  4  flags presented to the ALU; registered
- loadFlagsFromSavedState  output  1  one-cycle load strobe to the ALU; registered
- busy  output  1  high in every state except IDLE
- switchDone  output  1  one-cycle completion pulse
- slotValid  output  2**slotBits  per-slot valid bits

Behaviour:
- Reset (async, any state): state=IDLE; all slot data and valid bits cleared; savedFlags=0, loadFlagsFromSavedState=0, switchDone=0. No load is issued after reset deasserts.
- States: IDLE, SAVE, RESTORE, SETTLE, DONE.
- IDLE + switchRequest:
  - doSave=1: latch fromSlot/toSlot/doRestore, go to SAVE.
  - doSave=0, doRestore=1: go to RESTORE.
  - Both 0: go to DONE (empty switch still pulses switchDone).
- Slot indices are latched at acceptance. Input changes while busy are ignored.
- SAVE:
  - aluUpdateFlags=1: stay in SAVE (stall); ALU flags are changing this edge.
  - aluUpdateFlags=0: write aluFlags to slot[fromSlot], set valid. Next state is RESTORE if doRestore was latched, else DONE.
  - Stall is unbounded; the controller must quiesce the ALU.
- Entering RESTORE: register savedFlags = slot[toSlot] data if valid, else 4'b0000. loadFlagsFromSavedState=1 for exactly the RESTORE cycle. ALU captures at the end of RESTORE.
- RESTORE -> SETTLE (loadFlagsFromSavedState=0, savedFlags held) -> DONE.
- DONE: switchDone=1 for one cycle -> IDLE.
- Latency:
  - save+restore = 5 cycles from accepting edge to switchDone, with no stalls.
  - save only = 3 cycles.
  - restore only = 4 cycles.
- fromSlot==toSlot with both phases: restore returns the value just saved (write completes in SAVE before RESTORE reads).
- switchRequest while busy: ignored, not queued.
- invalidate while busy: ignored. Invalidate and switchRequest in the same IDLE cycle: both take effect; the switch sees the slot as invalid if it restores that slot.
- savedFlags holds its last value in IDLE. Only the load strobe is meaningful to the ALU.

Optional Feature:
- Macro: FLAG_STORE_PARITY_EN.
- Enabled:
  - Each slot stores an even-parity bit over its 4 flags.
  - On restore, a parity mismatch on a valid slot forces savedFlags=0 (load strobe still issued).
  - Sets a sticky output parityError (1 bit, cleared only by reset).
- Disabled: no parity storage, no parityError port, no check.

Test Plan:
- Reset mid-switch: assert reset during RESTORE -> loadFlagsFromSavedState=0 immediately (async), slotValid=0, busy=0, and no strobe after release.
- Save then restore: aluFlags=4'b1010, save to slot 2, restore slot 5 (invalid) -> savedFlags=0000 strobed 2 cycles after accept; switchDone at cycle 5; slotValid[2]=1.
- Round trip: save 4'b0111 to slot 3; later save 4'b1000 to slot 1 with restore slot 3 -> savedFlags=0111 with strobe exactly one cycle; slot 1 holds 1000.
- Stall: aluUpdateFlags=1 for 3 cycles in SAVE while aluFlags changes 0001->0100 -> stored value is the value when aluUpdateFlags drops (0100); switchDone at cycle 8.
- Same slot: fromSlot=toSlot=6, aluFlags=1101 -> savedFlags=1101 on strobe.
- Busy/invalidate: second switchRequest during busy -> ignored, exactly one switchDone. Invalidate slot 3 in IDLE, then restore 3 -> savedFlags=0000. With FLAG_STORE_PARITY_EN, a forced data bit flip in slot 3 -> savedFlags=0000 and parityError=1.

Source files
------------

// File: rtl/alu_flag_context_store.sv
// alu_flag_context_store
// Keeps one {Z,S,C,V} flag snapshot per process slot so the scheduler can
// park the ALU flags of the outgoing process and reinstate those of the
// incoming one. A switch walks IDLE -> SAVE -> RESTORE -> SETTLE -> DONE,
// skipping the phases that were not requested.
//
// Optional build macro: FLAG_STORE_PARITY_EN
//   Adds an even-parity bit per slot, zeroes restored flags on a parity
//   mismatch and exposes a sticky parityError output.

module alu_flag_context_store #(
  parameter int slotBits = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       switchRequest,
  input  logic                       doSave,
  input  logic                       doRestore,
  input  logic [slotBits-1:0]        fromSlot,
  input  logic [slotBits-1:0]        toSlot,
  input  logic                       invalidate,
  input  logic [slotBits-1:0]        invalidateSlot,
  input  logic [3:0]                 aluFlags,
  input  logic                       aluUpdateFlags,
  output logic [3:0]                 savedFlags,
  output logic                       loadFlagsFromSavedState,
  output logic                       busy,
  output logic                       switchDone,
  output logic [(2**slotBits)-1:0]   slotValid
`ifdef FLAG_STORE_PARITY_EN
  ,
  output logic                       parityError
`endif
);

  localparam int NUM_SLOTS = 2 ** slotBits;

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    RESTORE,
    SETTLE,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  // Switch parameters captured when the request is accepted
  logic [slotBits-1:0] from_q;
  logic [slotBits-1:0] to_q;
  logic                restore_q;

  // Per-slot flag storage (valid bits live directly in slotValid)
  logic [3:0]          slot_data [NUM_SLOTS];

  logic                accept;
  logic                write_slot;
  logic                do_invalidate;

  // Read path for the restore phase
  logic [slotBits-1:0] rd_idx;
  logic                rd_valid;
  logic [3:0]          rd_data;
  logic                parity_bad;
  logic [3:0]          restore_value;

`ifdef FLAG_STORE_PARITY_EN
  logic [NUM_SLOTS-1:0] slot_parity;
  logic                 rd_parity;
`endif

  assign busy = (state != IDLE);

  // Next-state decode plus the one-cycle actions (accept, slot write, invalidate)
  always_comb begin
    next_state    = state;
    accept        = 1'b0;
    write_slot    = 1'b0;
    do_invalidate = 1'b0;
    case (state)
      IDLE: begin
        do_invalidate = invalidate;
        if (switchRequest) begin
          accept = 1'b1;
          if (doSave) begin
            next_state = SAVE;
          end else if (doRestore) begin
            next_state = RESTORE;
          end else begin
            next_state = DONE;
          end
        end
      end
      SAVE: begin
        // While the ALU is still updating its flags the snapshot would be stale
        if (!aluUpdateFlags) begin
          write_slot = 1'b1;
          next_state = restore_q ? RESTORE : DONE;
        end
      end
      RESTORE: next_state = SETTLE;
      SETTLE:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Select the flags that will be presented when RESTORE is entered, with
  // bypasses for a same-cycle save of that slot and a same-cycle invalidate
  always_comb begin
    rd_idx   = (state == IDLE) ? toSlot : to_q;
    rd_valid = slotValid[rd_idx];
    rd_data  = slot_data[rd_idx];
`ifdef FLAG_STORE_PARITY_EN
    rd_parity = slot_parity[rd_idx];
`endif
    if ((state == SAVE) && (from_q == to_q)) begin
      rd_valid = 1'b1;
      rd_data  = aluFlags;
`ifdef FLAG_STORE_PARITY_EN
      rd_parity = ^aluFlags;
`endif
    end
    if ((state == IDLE) && invalidate && (invalidateSlot == toSlot)) begin
      rd_valid = 1'b0;
    end
`ifdef FLAG_STORE_PARITY_EN
    parity_bad = rd_valid && ((^rd_data) != rd_parity);
`else
    parity_bad = 1'b0;
`endif
    restore_value = (rd_valid && !parity_bad) ? rd_data : 4'b0000;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture slot indices and the restore qualifier at acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      from_q    <= '0;
      to_q      <= '0;
      restore_q <= 1'b0;
    end else if (accept) begin
      from_q    <= fromSlot;
      to_q      <= toSlot;
      restore_q <= doRestore;
    end
  end

  // Slot storage: save writes data and sets valid, invalidate clears valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_data[i] <= 4'b0000;
      end
      slotValid <= '0;
`ifdef FLAG_STORE_PARITY_EN
      slot_parity <= '0;
`endif
    end else if (write_slot) begin
      slot_data[from_q] <= aluFlags;
      slotValid[from_q] <= 1'b1;
`ifdef FLAG_STORE_PARITY_EN
      slot_parity[from_q] <= ^aluFlags;
`endif
    end else if (do_invalidate) begin
      slotValid[invalidateSlot] <= 1'b0;
    end
  end

  // Registered ALU-facing outputs and the completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      savedFlags              <= 4'b0000;
      loadFlagsFromSavedState <= 1'b0;
      switchDone              <= 1'b0;
    end else begin
      if (next_state == RESTORE) begin
        savedFlags <= restore_value;
      end
      loadFlagsFromSavedState <= (next_state == RESTORE);
      switchDone              <= (next_state == DONE);
    end
  end

`ifdef FLAG_STORE_PARITY_EN
  // Sticky record of any corrupted slot seen on restore
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parityError <= 1'b0;
    end else if ((next_state == RESTORE) && parity_bad) begin
      parityError <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_flag_context_store.sv
// Testbench for alu_flag_context_store: directed switches whose expected
// strobe values and completion cycles are queued at issue time and checked
// by an independent monitor when the DUT presents them.

module tb_alu_flag_context_store;

  logic       clk;
  logic       reset;
  logic       switchRequest;
  logic       doSave;
  logic       doRestore;
  logic [2:0] fromSlot;
  logic [2:0] toSlot;
  logic       invalidate;
  logic [2:0] invalidateSlot;
  logic [3:0] aluFlags;
  logic       aluUpdateFlags;
  logic [3:0] savedFlags;
  logic       loadFlagsFromSavedState;
  logic       busy;
  logic       switchDone;
  logic [7:0] slotValid;
`ifdef FLAG_STORE_PARITY_EN
  logic       parityError;
`endif

  typedef struct {
    logic [3:0] flags;
    int         cyc;
  } strobe_t;

  strobe_t strobe_q[$];
  int      done_q[$];
  int      cyc;
  int      total;
  int      bad;

  alu_flag_context_store #(.slotBits(3)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .switchRequest          (switchRequest),
    .doSave                 (doSave),
    .doRestore              (doRestore),
    .fromSlot               (fromSlot),
    .toSlot                 (toSlot),
    .invalidate             (invalidate),
    .invalidateSlot         (invalidateSlot),
    .aluFlags               (aluFlags),
    .aluUpdateFlags         (aluUpdateFlags),
    .savedFlags             (savedFlags),
    .loadFlagsFromSavedState(loadFlagsFromSavedState),
    .busy                   (busy),
    .switchDone             (switchDone),
    .slotValid              (slotValid)
`ifdef FLAG_STORE_PARITY_EN
    ,
    .parityError            (parityError)
`endif
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter referenced by the latency expectations
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a load or finishes
  always @(negedge clk) begin
    if (!reset) begin
      if (loadFlagsFromSavedState) begin
        if (strobe_q.size() == 0) begin
          checkOutput("unexpected_strobe", 1, 0);
        end else begin
          strobe_t e;
          e = strobe_q.pop_front();
          checkOutput("strobe_flags", {28'd0, savedFlags}, {28'd0, e.flags});
          checkOutput("strobe_cycle", cyc, e.cyc);
        end
      end
      if (switchDone) begin
        if (done_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          int d;
          d = done_q.pop_front();
          checkOutput("done_cycle", cyc, d);
        end
      end
    end
  end

  // Issue one context switch and queue the expected strobe / completion
  task automatic applyStimulus(input logic sv, input logic rs,
                               input logic [2:0] fr, input logic [2:0] to,
                               input logic [3:0] fStart, input logic [3:0] fFinal,
                               input int stall, input logic [3:0] expFlags,
                               input logic extraReq, input logic invSame,
                               input logic invBusy, input logic [2:0] invSlot);
    int      acc;
    int      n;
    strobe_t e;
    @(negedge clk);
    acc = cyc + 1;
    if (rs) begin
      e.flags = expFlags;
      e.cyc   = sv ? acc + 1 + stall : acc;
      strobe_q.push_back(e);
    end
    if (sv) done_q.push_back(rs ? acc + 3 + stall : acc + 1 + stall);
    else    done_q.push_back(rs ? acc + 2 : acc);
    switchRequest  = 1'b1;
    doSave         = sv;
    doRestore      = rs;
    fromSlot       = fr;
    toSlot         = to;
    aluFlags       = (sv && stall > 0) ? fStart : fFinal;
    aluUpdateFlags = sv && (stall > 0);
    invalidate     = invSame;
    invalidateSlot = invSlot;
    @(negedge clk);
    switchRequest = 1'b0;
    invalidate    = 1'b0;
    if (extraReq) begin
      switchRequest = 1'b1;
      doSave        = 1'b1;
      doRestore     = 1'b1;
      fromSlot      = 3'd5;
      toSlot        = 3'd5;
    end
    if (invBusy) begin
      invalidate     = 1'b1;
      invalidateSlot = invSlot;
    end
    if (sv && stall > 0) begin
      for (int i = 1; i <= stall; i++) begin
        if (i == 2) aluFlags = ~fFinal;
        @(negedge clk);
      end
      aluUpdateFlags = 1'b0;
      aluFlags       = fFinal;
    end
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      switchRequest = 1'b0;
      invalidate    = 1'b0;
      n++;
    end
    if (busy) checkOutput("busy_timeout", 1, 0);
  endtask

  initial begin
    strobe_t e;
    int      acc;
    total          = 0;
    bad            = 0;
    reset          = 1'b1;
    switchRequest  = 1'b0;
    doSave         = 1'b0;
    doRestore      = 1'b0;
    fromSlot       = 3'd0;
    toSlot         = 3'd0;
    invalidate     = 1'b0;
    invalidateSlot = 3'd0;
    aluFlags       = 4'b0000;
    aluUpdateFlags = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    checkOutput("reset_savedFlags", {28'd0, savedFlags}, 0);
    checkOutput("reset_load", {31'd0, loadFlagsFromSavedState}, 0);
    checkOutput("reset_busy", {31'd0, busy}, 0);
    checkOutput("reset_done", {31'd0, switchDone}, 0);
    checkOutput("reset_slotValid", {24'd0, slotValid}, 0);

    // Save only: 0011 into slot 0
    applyStimulus(1, 0, 3'd0, 3'd0, 4'b0011, 4'b0011, 0, 4'b0000, 0, 0, 0, 3'd0);
    checkOutput("save_only_valid", {24'd0, slotValid}, 32'h01);

    // Reset while the RESTORE strobe is up
    @(negedge clk);
    acc     = cyc + 1;
    e.flags = 4'b0011;
    e.cyc   = acc + 1;
    strobe_q.push_back(e);
    switchRequest = 1'b1;
    doSave        = 1'b1;
    doRestore     = 1'b1;
    fromSlot      = 3'd4;
    toSlot        = 3'd0;
    aluFlags      = 4'b1111;
    @(negedge clk);
    switchRequest = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mid_load", {31'd0, loadFlagsFromSavedState}, 0);
    checkOutput("rst_mid_valid", {24'd0, slotValid}, 0);
    checkOutput("rst_mid_busy", {31'd0, busy}, 0);
    checkOutput("rst_mid_saved", {28'd0, savedFlags}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("rst_after_busy", {31'd0, busy}, 0);

    // Save 1010 to slot 2, restore never-saved slot 5
    applyStimulus(1, 1, 3'd2, 3'd5, 4'b1010, 4'b1010, 0, 4'b0000, 0, 0, 0, 3'd0);
    checkOutput("save_restore_valid", {24'd0, slotValid}, 32'h04);

    // Round trip through slot 3, then slot 1
    applyStimulus(1, 0, 3'd3, 3'd0, 4'b0111, 4'b0111, 0, 4'b0000, 0, 0, 0, 3'd0);
    applyStimulus(1, 1, 3'd1, 3'd3, 4'b1000, 4'b1000, 0, 4'b0111, 0, 0, 0, 3'd0);
    applyStimulus(0, 1, 3'd0, 3'd1, 4'b0000, 4'b0000, 0, 4'b1000, 0, 0, 0, 3'd0);
    checkOutput("round_trip_valid", {24'd0, slotValid}, 32'h0E);

    // Three stall cycles: slot 0 must hold the value present when the stall ends
    applyStimulus(1, 1, 3'd0, 3'd3, 4'b0001, 4'b0100, 3, 4'b0111, 0, 0, 0, 3'd0);
    applyStimulus(0, 1, 3'd0, 3'd0, 4'b0000, 4'b0000, 0, 4'b0100, 0, 0, 0, 3'd0);

    // Save and restore the same slot
    applyStimulus(1, 1, 3'd6, 3'd6, 4'b1101, 4'b1101, 0, 4'b1101, 0, 0, 0, 3'd0);

    // Second request while busy must be dropped
    applyStimulus(0, 1, 3'd0, 3'd6, 4'b0110, 4'b0110, 0, 4'b1101, 1, 0, 0, 3'd0);
    checkOutput("busy_req_ignored", {24'd0, slotValid}, 32'h4F);

    // Stand-alone invalidate of slot 3, then restore it
    @(negedge clk);
    invalidate     = 1'b1;
    invalidateSlot = 3'd3;
    @(negedge clk);
    invalidate = 1'b0;
    checkOutput("invalidate_valid", {24'd0, slotValid}, 32'h47);
    applyStimulus(0, 1, 3'd0, 3'd3, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 3'd0);

    // Invalidate and restore slot 1 in the same cycle
    applyStimulus(0, 1, 3'd0, 3'd1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 0, 3'd1);
    checkOutput("inval_same_valid", {24'd0, slotValid}, 32'h45);

    // Invalidate while busy must be dropped
    applyStimulus(0, 1, 3'd0, 3'd6, 4'b0000, 4'b0000, 0, 4'b1101, 0, 0, 1, 3'd6);
    checkOutput("inval_busy_valid", {24'd0, slotValid}, 32'h45);

    // Empty switch still completes
    applyStimulus(0, 0, 3'd0, 3'd0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 3'd0);

    repeat (4) @(negedge clk);
    checkOutput("strobe_q_empty", strobe_q.size(), 0);
    checkOutput("done_q_empty", done_q.size(), 0);
`ifdef FLAG_STORE_PARITY_EN
    checkOutput("parity_clean", {31'd0, parityError}, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
